// File: rtl/col_result_serializer.sv
// Buffers adder-column result vectors with their visible-row masks in a small FIFO and
// serialises the visible rows, lowest index first, onto a valid/ready stream.
module col_result_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_ROWS   = 4,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned RowW      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int unsigned CntW      = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_ROWS-1:0]            in_visible,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [RowW-1:0]                out_row,
    output logic                           out_last,
    output logic [CntW-1:0]                fifo_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned VecW = NUM_ROWS * DATA_WIDTH;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                state_q, state_d;
    logic [VecW-1:0]       mem_data [DEPTH];
    logic [NUM_ROWS-1:0]   mem_mask [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q;
    logic [VecW-1:0]       cur_data_q, cur_data_d;
    logic [NUM_ROWS-1:0]   cur_mask_q, cur_mask_d;
    logic [NUM_ROWS-1:0]   low_bit, mask_left;
    logic                  push, pop;

    assign in_ready   = (count_q != CntW'(DEPTH));
    assign fifo_count = count_q;
    // Empty-mask vectors are handshaken but never stored.
    assign push       = !rst && in_valid && in_ready && (in_visible != '0);

    assign low_bit    = cur_mask_q & (~cur_mask_q + NUM_ROWS'(1));
    assign mask_left  = cur_mask_q & ~low_bit;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        cur_data_d = cur_data_q;
        cur_mask_d = cur_mask_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (out_ready) begin
                    cur_mask_d = mask_left;
                    if (mask_left == '0) begin
                        if (count_q != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
        endcase
        if (pop) begin
            cur_data_d = mem_data[rd_ptr_q];
            cur_mask_d = mem_mask[rd_ptr_q];
        end
    end

    always_comb begin
        out_valid = (state_q == StSend);
        out_data  = '0;
        out_row   = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            // Descending scan so the lowest set bit wins.
            for (int r = NUM_ROWS - 1; r >= 0; r--) begin
                if (cur_mask_q[r]) begin
                    out_row  = RowW'(r);
                    out_data = cur_data_q[r*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            out_last = (mask_left == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= in_data;
            mem_mask[wr_ptr_q] <= in_visible;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cur_data_q <= '0;
            cur_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_data_q <= cur_data_d;
            cur_mask_q <= cur_mask_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

endmodule

// File: tb/tb_col_result_serializer.sv
// Scoreboard bench for col_result_serializer: directed scenarios plus randomized traffic,
// expected beats derived from each accepted vector's mask.
module tb_col_result_serializer;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] row;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_visible;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_row;
    logic        out_last;
    logic [2:0]  fifo_count;

    beat_t       exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          prev_hs = -1;
    int          gaps = 0;
    int          rdy_mode = 0;
    logic        stall_q = 1'b0;
    logic [11:0] stall_snap = '0;

    col_result_serializer #(
        .DATA_WIDTH(8),
        .NUM_ROWS  (4),
        .DEPTH     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_visible(in_visible),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one beat per set mask bit, ascending, last on the highest set bit.
    function automatic void expect_vec(input logic [31:0] data, input logic [3:0] mask);
        int    last_r;
        beat_t b;
        last_r = -1;
        for (int r = 0; r < 4; r++) if (mask[r]) last_r = r;
        for (int r = 0; r < 4; r++) begin
            if (mask[r]) begin
                b.data = data[r*8 +: 8];
                b.row  = 2'(r);
                b.last = (r == last_r);
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic send_vec(input logic [31:0] data, input logic [3:0] mask);
        int waited;
        bit ok;
        waited = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = data;
        in_visible = mask;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (in_ready === 1'b1) ok = 1'b1;
            else waited++;
        end
        if (ok) expect_vec(data, mask);
        else check("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid !== 1'b0 || fifo_count !== 3'd0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_row", 32'(out_row), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1: out_ready = 1'b1;
            2: out_ready = !out_ready;
            3: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // Monitor: values seen at the negedge are those the next rising edge samples.
    initial forever begin
        beat_t e;
        beat_t got;
        @(negedge clk);
        if (rst === 1'b0) begin
            if (stall_q)
                check("stall_hold", {20'd0, out_valid, out_data, out_row, out_last},
                      {20'd0, stall_snap});
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                hs_count++;
                if (prev_hs >= 0 && prev_hs != cyc - 1) gaps++;
                prev_hs = cyc;
                got = {out_data, out_row, out_last};
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got data %0h row %0d last %0b, expected none",
                             out_data, out_row, out_last);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'(got), 32'(e));
                end
            end
            stall_q = (out_valid === 1'b1 && out_ready === 1'b0);
            stall_snap = {out_valid, out_data, out_row, out_last};
        end else begin
            stall_q = 1'b0;
        end
    end

    initial begin
        logic [3:0] wrap_masks [3];
        int         hs0;
        wrap_masks = '{4'b1000, 4'b0110, 4'b1111};
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_visible = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;

        // Basic selection and two-cycle latency
        out_ready = 1'b1;
        send_vec({8'd125, 8'd230, 8'd25, 8'd30}, 4'b1011);
        check("lat_k_valid", 32'(out_valid), 32'd0);
        check("lat_k_count", 32'(fifo_count), 32'd1);
        @(posedge clk);
        #1;
        check("lat_k1_valid", 32'(out_valid), 32'd1);
        check("lat_k1_data", 32'(out_data), 32'd30);
        wait_drain();

        // Empty mask is dropped
        send_vec(32'hdeadbeef, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            check("empty_count", 32'(fifo_count), 32'd0);
            check("empty_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        // Fill under back-pressure: DEPTH+1 vectors held
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_vec({24'ha5a5a5, 8'(8'h40 + i)}, 4'b0001);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_out_data", 32'(out_data), 32'h40);
        in_valid = 1'b1;
        in_data = 32'h12345699;
        in_visible = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sixth_blocked", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rdy_mode = 1;
        wait_drain();
        check("drained_in_ready", 32'(in_ready), 32'd1);

        // Stall stability with toggling ready
        rdy_mode = 2;
        send_vec($urandom, 4'b1111);
        wait_drain();

        // Back-to-back vectors across pointer wrap, no bubbles
        rdy_mode = 1;
        gaps = 0;
        prev_hs = -1;
        hs0 = hs_count;
        for (int i = 0; i < 10; i++) send_vec($urandom, wrap_masks[i % 3]);
        wait_drain();
        check("wrap_gaps", 32'(gaps), 32'd0);
        check("wrap_beats", 32'(hs_count - hs0), 32'd22);

        // Reset mid-vector with a partly full FIFO
        rdy_mode = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_vec($urandom, 4'b1111);
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("pre_rst_row", 32'(out_row), 32'd1);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = $urandom;
        in_visible = 4'b1111;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_count", 32'(fifo_count), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        rdy_mode = 1;
        send_vec(32'h11223344, 4'b0101);
        wait_drain();

        // Randomized traffic
        rdy_mode = 3;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_vec($urandom, 4'($urandom_range(0, 15)));
        end
        rdy_mode = 1;
        wait_drain();
        check("final_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
